// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: reset PC, prefetch depth, NOP encoding and the queue entry type.
package fetch_sequencer_pkg;

    localparam logic [31:0] FETCH_RESET_PC    = 32'h0000_0000;
    localparam int          FETCH_QUEUE_DEPTH = 2;
    localparam logic [31:0] I_NOP             = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Redirect targets are word addresses; the low two bits carry no meaning.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: ROM address/data, decode handshake, execute redirect and fault flag.
interface fetch_sequencer_if;

    logic [31:0] addr_bus;
    logic [31:0] data_bus;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output addr_bus, instr_valid, instr, instr_pc, fetch_fault,
        input  data_bus, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  addr_bus, instr_valid, instr, instr_pc, fetch_fault,
        output data_bus, instr_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO of {pc, word}; entry 0 is always the head so outputs come straight from flops.
module fetch_queue
    import fetch_sequencer_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_d = wdata_i;
                    else               ent1_d = wdata_i;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever survives the pop.
                    if (cnt_q == 2'd1) begin
                        ent0_d = wdata_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = wdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o  = ent0_q;
    assign full_o  = (cnt_q == 2'(FETCH_QUEUE_DEPTH));
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// RV32E fetch controller: fetch PC, push/pop/redirect control around a 2-entry prefetch queue.
// Optional ROM bounds check with fault/halt is compiled in by defining FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int unsigned ROM_WORDS = 513
)(
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_sequencer: RESET_PC must be word aligned");
    end
    if (ROM_WORDS == 0) begin : g_bad_rom_words
        $error("fetch_sequencer: ROM_WORDS must be non-zero");
    end

    logic [31:0]  pc_q, pc_d;
    logic         pop, want_push, push;
    logic         full, empty;
    fetch_entry_t head, wdata;

    assign pop       = !empty && bus.instr_ready;
    // A pop frees a slot in the same cycle, so a full queue still streams.
    assign want_push = !bus.redirect_valid && (!full || pop);
    assign wdata     = '{pc: pc_q, word: bus.data_bus};

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;

    logic fault_q, fault_d;
    logic in_range;

    assign in_range = ({1'b0, pc_q} < ROM_LIMIT);
    assign push     = want_push && in_range && !fault_q;

    always_comb begin
        fault_d = fault_q;
        if (bus.redirect_valid)          fault_d = 1'b0;
        else if (want_push && !in_range) fault_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign bus.fetch_fault = fault_q;
`else
    assign push            = want_push;
    assign bus.fetch_fault = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = word_align(bus.redirect_pc);
        else if (push)          pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (wdata),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.addr_bus    = pc_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = head.word;
    assign bus.instr_pc    = head.pc;

endmodule
